count_monitor: RTL

- Passive reader for the loadable up/down counter. It sits beside the counter and samples the counter's control inputs and its count output every cycle.
- It predicts each next count value, flags mismatches and keeps a saturating error count.
- Used both as an embedded checker in simulation and as a synthesizable health monitor on the counter output bus.

---
 rtl/count_monitor.sv | 87 ++++++++
 1 files changed

// File: rtl/count_monitor.sv
// count_monitor: passive checker for a loadable up/down counter; define COUNT_MON_WRAP_EN for wrap_up/wrap_down pulses
module count_monitor #(
    parameter int N = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             enable,
    input  logic             s,
    input  logic [N-1:0]     in,
    input  logic [N-1:0]     cnt,
    output logic [N-1:0]     exp,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fault,
    output logic [1:0]       state
`ifdef COUNT_MON_WRAP_EN
    ,
    output logic             wrap_up,
    output logic             wrap_down
`endif
);
    typedef enum logic [1:0] {UNSYNC = 2'b00, TRACK = 2'b01, FAULT = 2'b10} state_t;
    state_t st, st_nx;
    logic [N-1:0] cnt_q, in_q;
    logic load_q, enable_q, s_q;
    logic live, miss;
    assign state = st;
    assign live = st != UNSYNC;
    assign miss = live && cnt != exp;
    // prediction of the current cnt from last cycle's observed counter inputs
    always_comb exp = load_q ? in_q : enable_q ? (s_q ? cnt_q - 1'b1 : cnt_q + 1'b1) : cnt_q;
    // UNSYNC syncs after one sample; any mismatch latches FAULT until clr or rst
    always_comb st_nx = clr ? UNSYNC : st == UNSYNC ? TRACK : miss ? FAULT : st;
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) st <= UNSYNC;
        else st <= st_nx;
    // sample registers always take the observed cnt, so FAULT resyncs on reality
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt_q <= '0;
            in_q <= '0;
            load_q <= 1'b0;
            enable_q <= 1'b0;
            s_q <= 1'b0;
        end else begin
            cnt_q <= cnt;
            in_q <= in;
            load_q <= load;
            enable_q <= enable;
            s_q <= s;
        end
    // error pulse, saturating error count and sticky fault; clr discards a same-cycle mismatch
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            err <= 1'b0;
            err_cnt <= '0;
            fault <= 1'b0;
        end else if (clr) begin
            err <= 1'b0;
            err_cnt <= '0;
            fault <= 1'b0;
        end else begin
            err <= miss;
            if (miss) begin
                fault <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
        end
`ifdef COUNT_MON_WRAP_EN
    // wrap pulses only for correctly predicted enable-driven boundary crossings
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wrap_up <= 1'b0;
            wrap_down <= 1'b0;
        end else if (clr) begin
            wrap_up <= 1'b0;
            wrap_down <= 1'b0;
        end else begin
            wrap_up <= live && !miss && enable_q && !load_q && !s_q && cnt_q == '1;
            wrap_down <= live && !miss && enable_q && !load_q && s_q && cnt_q == '0;
        end
`endif
endmodule
